// File: rtl/fm_pkg.sv
// fm_pkg: shared definitions for the FM envelope-generator controller.
//   - eg_stage_e : envelope stage encoding as stored in the envelope RAM
//   - eg_fsm_e   : sequencer states
//   - CNT_W / ATT_W / STEP_SHIFT : counter, attenuation and step geometry
//   - eg_step()  : rate nibble -> counter increment
package fm_pkg;

  localparam int CNT_W      = 24;  // envelope counter width
  localparam int ATT_W      = 10;  // attenuation = top ATT_W bits of the counter
  localparam int STEP_SHIFT = 8;   // step(r) = 1 << (r + STEP_SHIFT)

  typedef enum logic [1:0] {
    EG_ATTACK  = 2'd0,
    EG_DECAY   = 2'd1,
    EG_SUSTAIN = 2'd2,
    EG_RELEASE = 2'd3
  } eg_stage_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_WR
  } eg_fsm_e;

  // Rate 0 freezes the counter; rate 15 gives the largest step, 2^23.
  function automatic logic [CNT_W-1:0] eg_step(input logic [3:0] rate);
    if (rate == 4'd0) return '0;
    return CNT_W'(1) << (int'(rate) + STEP_SHIFT);
  endfunction

endpackage

// File: rtl/fm_eg_ctrl_if.sv
// fm_eg_ctrl_if: port bundle between the envelope controller and the
// 64-slot envelope-state RAM (asynchronous read, synchronous write).
//   o_ram_idx     : address for both read and write
//   o_ram_wren    : write enable
//   o_ram_stage   : write data, stage
//   o_ram_env_cnt : write data, counter
//   i_ram_stage   : read data, stage
//   i_ram_env_cnt : read data, counter
// master = controller side, slave = RAM side.
interface fm_eg_ctrl_if;
  import fm_pkg::*;

  logic [5:0]       o_ram_idx;
  logic             o_ram_wren;
  logic [1:0]       o_ram_stage;
  logic [CNT_W-1:0] o_ram_env_cnt;
  logic [1:0]       i_ram_stage;
  logic [CNT_W-1:0] i_ram_env_cnt;

  modport master (
    output o_ram_idx, o_ram_wren, o_ram_stage, o_ram_env_cnt,
    input  i_ram_stage, i_ram_env_cnt
  );

  modport slave (
    input  o_ram_idx, o_ram_wren, o_ram_stage, o_ram_env_cnt,
    output i_ram_stage, i_ram_env_cnt
  );

endinterface

// File: rtl/fm_eg_step.sv
// fm_eg_step: combinational next-state for one envelope slot.
//   stage_i/cnt_i        : current stage and counter from the RAM
//   ar_i dr_i sr_i rr_i  : per-stage rates
//   sl_i                 : sustain level, compared with cnt[23:20]
//   kon_i/koff_i         : pending key events sampled for this slot
//   stage_o/cnt_o        : state to write back
// A key event only changes the stage; the counter then moves with the
// rate of the stage the key event selected.
module fm_eg_step
  import fm_pkg::*;
(
  input  eg_stage_e        stage_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [3:0]       ar_i,
  input  logic [3:0]       dr_i,
  input  logic [3:0]       sr_i,
  input  logic [3:0]       rr_i,
  input  logic [3:0]       sl_i,
  input  logic             kon_i,
  input  logic             koff_i,
  output eg_stage_e        stage_o,
  output logic [CNT_W-1:0] cnt_o
);

  eg_stage_e        stage_eff;
  logic [3:0]       rate;
  logic [CNT_W-1:0] step;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   diff;

  // NOTE: every variable written in always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stage_eff = stage_i;
    if (kon_i) begin
      stage_eff = EG_ATTACK;
    end else if (koff_i && stage_i != EG_RELEASE) begin
      stage_eff = EG_RELEASE;
    end

    rate = rr_i;
    case (stage_eff)
      EG_ATTACK:  rate = ar_i;
      EG_DECAY:   rate = dr_i;
      EG_SUSTAIN: rate = sr_i;
      default:    rate = rr_i;
    endcase

    step = eg_step(rate);
    // One extra bit catches the borrow / carry used for saturation.
    sum  = {1'b0, cnt_i} + {1'b0, step};
    diff = {1'b0, cnt_i} - {1'b0, step};

    stage_o = stage_eff;
    cnt_o   = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    case (stage_eff)
      EG_ATTACK: begin
        cnt_o = diff[CNT_W] ? '0 : diff[CNT_W-1:0];
        if (cnt_o == '0) stage_o = EG_DECAY;
      end
      EG_DECAY: begin
        if (cnt_o[CNT_W-1 -: 4] >= sl_i) stage_o = EG_SUSTAIN;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fm_eg_ctrl.sv
// fm_eg_ctrl: envelope sequencer. After reset it fills the envelope RAM
// with silent RELEASE entries; afterwards each i_tick walks all NUM_OPS
// slots (RD then WR per slot), applying pending key events, advancing the
// envelope and emitting the new attenuation for the operator datapath.
//   clk, reset               : clock, synchronous active-high reset
//   i_tick                   : starts one pass; o_overrun if busy
//   i_key_valid/idx/on       : key event, always accepted
//   o_cfg_idx, i_ar..i_sl    : per-slot configuration lookup (same cycle)
//   ram                      : envelope RAM port bundle
//   o_env_valid/idx/att      : one-cycle attenuation result per slot
//   o_busy                   : init or pass in progress
module fm_eg_ctrl
  import fm_pkg::*;
#(
  parameter int NUM_OPS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_tick,
  input  logic              i_key_valid,
  input  logic [5:0]        i_key_idx,
  input  logic              i_key_on,
  output logic [5:0]        o_cfg_idx,
  input  logic [3:0]        i_ar,
  input  logic [3:0]        i_dr,
  input  logic [3:0]        i_sr,
  input  logic [3:0]        i_rr,
  input  logic [3:0]        i_sl,
  fm_eg_ctrl_if.master      ram,
  output logic              o_env_valid,
  output logic [5:0]        o_env_idx,
  output logic [ATT_W-1:0]  o_env_att,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam logic [5:0] LAST_SLOT = 6'(NUM_OPS - 1);

  eg_fsm_e            state_q, state_d;
  logic [5:0]         slot_q, slot_d;
  logic [NUM_OPS-1:0] kon_p_q, kon_p_d;
  logic [NUM_OPS-1:0] koff_p_q, koff_p_d;
  logic               keep_q, keep_d;   // event hit this slot during its RD
  logic               overrun_q;

  // Slot snapshot taken in RD, consumed in WR.
  eg_stage_e          rd_stage_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic [3:0]         ar_q, dr_q, sr_q, rr_q, sl_q;
  logic               kon_s_q, koff_s_q;

  eg_stage_e          nxt_stage;
  logic [CNT_W-1:0]   nxt_cnt;
  logic               in_init, in_wr;

  assign in_init = (state_q == ST_INIT);
  assign in_wr   = (state_q == ST_WR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      slot_q    <= '0;
      kon_p_q   <= '0;
      koff_p_q  <= '0;
      keep_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      kon_p_q   <= kon_p_d;
      koff_p_q  <= koff_p_d;
      keep_q    <= keep_d;
      overrun_q <= i_tick && (state_q != ST_IDLE);
    end
  end

  // NOTE: the snapshot registers carry no reset: WR only ever follows an RD
  // that loaded them, so their power-up value is never observed.
  always_ff @(posedge clk) begin
    if (state_q == ST_RD) begin
      rd_stage_q <= eg_stage_e'(ram.i_ram_stage);
      rd_cnt_q   <= ram.i_ram_env_cnt;
      ar_q       <= i_ar;
      dr_q       <= i_dr;
      sr_q       <= i_sr;
      rr_q       <= i_rr;
      sl_q       <= i_sl;
      kon_s_q    <= kon_p_q[slot_q];
      koff_s_q   <= koff_p_q[slot_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    kon_p_d  = kon_p_q;
    koff_p_d = koff_p_q;
    keep_d   = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (slot_q == LAST_SLOT) begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 6'd1;
        end
      end
      ST_IDLE: begin
        if (i_tick) begin
          state_d = ST_RD;
          slot_d  = '0;
        end
      end
      ST_RD: begin
        state_d = ST_WR;
        // An event landing after the snapshot must not be wiped in WR.
        keep_d  = i_key_valid && (i_key_idx == slot_q);
      end
      ST_WR: begin
        if (!keep_q) begin
          kon_p_d[slot_q]  = 1'b0;
          koff_p_d[slot_q] = 1'b0;
        end
        if (slot_q == LAST_SLOT) begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end else begin
          state_d = ST_RD;
          slot_d  = slot_q + 6'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Applied last: a new event beats the WR clear, and the latest event
    // for a slot cancels the opposite pending one.
    if (i_key_valid) begin
      kon_p_d[i_key_idx]  = i_key_on;
      koff_p_d[i_key_idx] = !i_key_on;
    end
  end

  fm_eg_step u_step (
    .stage_i (rd_stage_q),
    .cnt_i   (rd_cnt_q),
    .ar_i    (ar_q),
    .dr_i    (dr_q),
    .sr_i    (sr_q),
    .rr_i    (rr_q),
    .sl_i    (sl_q),
    .kon_i   (kon_s_q),
    .koff_i  (koff_s_q),
    .stage_o (nxt_stage),
    .cnt_o   (nxt_cnt)
  );

  // Write strobes are gated with reset so nothing is written while reset
  // is held, whatever state the FSM was in.
  assign ram.o_ram_idx     = slot_q;
  assign ram.o_ram_wren    = !reset && (in_init || in_wr);
  assign ram.o_ram_stage   = in_init ? EG_RELEASE : nxt_stage;
  assign ram.o_ram_env_cnt = in_init ? '1 : nxt_cnt;

  assign o_cfg_idx   = slot_q;
  assign o_env_valid = !reset && in_wr;
  assign o_env_idx   = o_env_valid ? slot_q : '0;
  assign o_env_att   = o_env_valid ? nxt_cnt[CNT_W-1 -: ATT_W] : '0;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_fm_eg_ctrl.sv
module tb_fm_eg_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_tick;
  logic        i_key_valid;
  logic [5:0]  i_key_idx;
  logic        i_key_on;
  logic [5:0]  o_cfg_idx;
  logic [3:0]  i_ar, i_dr, i_sr, i_rr, i_sl;
  logic        o_env_valid;
  logic [5:0]  o_env_idx;
  logic [9:0]  o_env_att;
  logic        o_busy;
  logic        o_overrun;

  always #5 clk = ~clk;

  fm_eg_ctrl_if ram_if ();

  fm_eg_ctrl #(.NUM_OPS(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_tick      (i_tick),
    .i_key_valid (i_key_valid),
    .i_key_idx   (i_key_idx),
    .i_key_on    (i_key_on),
    .o_cfg_idx   (o_cfg_idx),
    .i_ar        (i_ar),
    .i_dr        (i_dr),
    .i_sr        (i_sr),
    .i_rr        (i_rr),
    .i_sl        (i_sl),
    .ram         (ram_if),
    .o_env_valid (o_env_valid),
    .o_env_idx   (o_env_idx),
    .o_env_att   (o_env_att),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  // Envelope RAM model: asynchronous read, synchronous write, no reset.
  logic [1:0]  mem_stage [64];
  logic [23:0] mem_cnt   [64];
  assign ram_if.i_ram_stage   = mem_stage[ram_if.o_ram_idx];
  assign ram_if.i_ram_env_cnt = mem_cnt[ram_if.o_ram_idx];
  always @(posedge clk) begin
    if (ram_if.o_ram_wren) begin
      mem_stage[ram_if.o_ram_idx] <= ram_if.o_ram_stage;
      mem_cnt[ram_if.o_ram_idx]   <= ram_if.o_ram_env_cnt;
    end
  end

  // Per-slot configuration, looked up by the slot the DUT presents.
  logic [3:0] cfg_ar [64];
  logic [3:0] cfg_dr [64];
  logic [3:0] cfg_sr [64];
  logic [3:0] cfg_rr [64];
  logic [3:0] cfg_sl [64];
  assign i_ar = cfg_ar[o_cfg_idx];
  assign i_dr = cfg_dr[o_cfg_idx];
  assign i_sr = cfg_sr[o_cfg_idx];
  assign i_rr = cfg_rr[o_cfg_idx];
  assign i_sl = cfg_sl[o_cfg_idx];

  typedef struct {
    logic [5:0]  idx;
    logic [1:0]  stage;
    logic [23:0] cnt;
  } exp_t;

  exp_t        exp_q [$];
  logic [1:0]  es [64];   // hand-tracked expected stage per slot
  logic [23:0] ec [64];   // hand-tracked expected counter per slot

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int ov_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_overrun) ov_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every o_env_valid consumes one expected entry.
  always @(negedge clk) begin : mon
    exp_t item;
    if (o_env_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_env: slot %0d att 0x%0h with empty queue", o_env_idx, o_env_att);
      end else begin
        item = exp_q.pop_front();
        check("env_idx",   64'(o_env_idx), 64'(item.idx));
        check("env_att",   64'(o_env_att), 64'(item.cnt[23:14]));
        check("wr_en_idx", {ram_if.o_ram_wren, ram_if.o_ram_idx}, {1'b1, item.idx});
        check("wr_stage",  64'(ram_if.o_ram_stage), 64'(item.stage));
        check("wr_cnt",    64'(ram_if.o_ram_env_cnt), 64'(item.cnt));
      end
    end
  end

  task automatic set_defaults();
    for (int s = 0; s < 64; s++) begin
      es[s] = 2'd3;
      ec[s] = 24'hFFFFFF;
    end
  endtask

  task automatic push_pass();
    exp_t e;
    for (int s = 0; s < 64; s++) begin
      e.idx   = 6'(s);
      e.stage = es[s];
      e.cnt   = ec[s];
      exp_q.push_back(e);
    end
  endtask

  task automatic start_tick();
    @(posedge clk); #1 i_tick = 1'b1;
    @(posedge clk); #1 i_tick = 1'b0;
    t0 = cyc;
  endtask

  task automatic finish_pass(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!o_busy) done = 1'b1;
    end
    check({name, "_ended"}, 64'(done), 64'd1);
    check({name, "_len"},   64'(cyc - t0), 64'd128);
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_pass(input string name);
    push_pass();
    start_tick();
    finish_pass(name);
  endtask

  task automatic key_evt(input int idx, input bit on);
    @(posedge clk); #1;
    i_key_valid = 1'b1;
    i_key_idx   = 6'(idx);
    i_key_on    = on;
    @(posedge clk); #1;
    i_key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int busy_seen;
    reset = 1'b1;
    i_tick = 1'b0;
    i_key_valid = 1'b0;
    i_key_idx = '0;
    i_key_on = 1'b0;
    for (int s = 0; s < 64; s++) begin
      mem_stage[s] = 2'd0;
      mem_cnt[s]   = 24'h123456;
      cfg_ar[s] = '0; cfg_dr[s] = '0; cfg_sr[s] = '0; cfg_rr[s] = '0; cfg_sl[s] = '0;
    end
    cfg_ar[5] = 4'd15; cfg_dr[5] = 4'd12; cfg_sl[5] = 4'd2;
    cfg_ar[9] = 4'd14;
    cfg_ar[7] = 4'd15;
    cfg_ar[11] = 4'd15;
    cfg_ar[3] = 4'd15;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wren",    64'(ram_if.o_ram_wren), 64'd0);
    check("rst_valid",   64'(o_env_valid), 64'd0);
    check("rst_env_idx", 64'(o_env_idx), 64'd0);
    check("rst_env_att", 64'(o_env_att), 64'd0);
    check("rst_overrun", 64'(o_overrun), 64'd0);
    check("rst_busy",    64'(o_busy), 64'd1);
    check("rst_ram_idx", 64'(ram_if.o_ram_idx), 64'd0);
    check("rst_cfg_idx", 64'(o_cfg_idx), 64'd0);

    // Initialisation: one RELEASE/all-ones write per cycle, then idle.
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("init_write",
            {o_busy, ram_if.o_ram_wren, ram_if.o_ram_idx, ram_if.o_ram_stage, ram_if.o_ram_env_cnt},
            {1'b1, 1'b1, 6'(i), 2'd3, 24'hFFFFFF});
    end
    @(negedge clk);
    check("init_busy_low", 64'(o_busy), 64'd0);

    set_defaults();
    run_pass("pass_silent");

    // Key-on slot 5, ar=15: 0xFFFFFF -> 0x7FFFFF -> 0 (DECAY).
    key_evt(5, 1'b1);
    es[5] = 2'd0; ec[5] = 24'h7FFFFF;
    run_pass("attack1");
    es[5] = 2'd1; ec[5] = 24'h000000;
    run_pass("attack2");

    // Decay with dr=12 (step 0x100000), sl=2.
    es[5] = 2'd1; ec[5] = 24'h100000;
    run_pass("decay1");
    es[5] = 2'd2; ec[5] = 24'h200000;
    run_pass("decay2");

    // Slot 9: key-on then key-off -> stays released.
    key_evt(9, 1'b1);
    key_evt(9, 1'b0);
    run_pass("kon_koff");
    // Slot 9: key-off then key-on -> attack, ar=14 (step 0x400000).
    key_evt(9, 1'b0);
    key_evt(9, 1'b1);
    es[9] = 2'd0; ec[9] = 24'hBFFFFF;
    run_pass("koff_kon");

    // Events for slot 7 in its WR and slot 11 in its RD wait a pass.
    es[9] = 2'd0; ec[9] = 24'h7FFFFF;
    push_pass();
    start_tick();
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (o_env_valid && o_env_idx == 6'd7) done = 1'b1;
    end
    check("found_wr7", 64'(done), 64'd1);
    i_key_valid = 1'b1; i_key_idx = 6'd7; i_key_on = 1'b1;
    @(posedge clk); #1 i_key_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (o_busy && !o_env_valid && o_cfg_idx == 6'd11) done = 1'b1;
    end
    check("found_rd11", 64'(done), 64'd1);
    i_key_valid = 1'b1; i_key_idx = 6'd11; i_key_on = 1'b1;
    @(posedge clk); #1 i_key_valid = 1'b0;
    finish_pass("late_events");

    es[9] = 2'd0; ec[9] = 24'h3FFFFF;
    es[7] = 2'd0; ec[7] = 24'h7FFFFF;
    es[11] = 2'd0; ec[11] = 24'h7FFFFF;
    run_pass("late_applied");
    check("no_overrun_yet", 64'(ov_cnt), 64'd0);

    // Tick at cycle 10 of a pass: one overrun pulse, no extra pass.
    es[9] = 2'd1; ec[9] = 24'h000000;
    es[7] = 2'd1; ec[7] = 24'h000000;
    es[11] = 2'd1; ec[11] = 24'h000000;
    push_pass();
    start_tick();
    repeat (9) @(posedge clk);
    #1 i_tick = 1'b1;
    @(posedge clk); #1 i_tick = 1'b0;
    finish_pass("overrun_pass");
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_busy) busy_seen++;
    end
    check("no_second_pass", 64'(busy_seen), 64'd0);
    check("overrun_once", 64'(ov_cnt), 64'd1);

    // Reset mid-pass with a key-on pending for slot 3: all discarded.
    key_evt(3, 1'b1);
    push_pass();
    start_tick();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!o_busy) done = 1'b1;
    end
    check("reinit_done", 64'(done), 64'd1);
    set_defaults();
    run_pass("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
